// File: rtl/nv_ram_rws_128x18_fifo_ctrl_pkg.sv
// Shared definitions for the 128x18 RAM family FIFO controller:
// geometry defaults, a ceil-log2 helper and the derived vector types.
package nv_ram_rws_128x18_fifo_ctrl_pkg;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int DEPTH = 128;
  localparam int AW    = clog2_f(DEPTH);
  localparam int DW    = 18;

  typedef logic [AW-1:0] addr_t;
  typedef logic [AW:0]   cnt_t;   // one extra bit so 0..DEPTH fits
  typedef logic [DW-1:0] data_t;

endpackage

// File: rtl/nv_ram_rws_128x18_fifo_ctrl_if.sv
// Bundle of the FIFO push/pop handshakes, the RAM port signals and the
// occupancy count. The slave side is the controller; the master side is
// the parent (producer, consumer and the RAM instance).
interface nv_ram_rws_128x18_fifo_ctrl_if import nv_ram_rws_128x18_fifo_ctrl_pkg::*; ();

  logic  flush;
  logic  wr_pvld;
  logic  wr_prdy;
  data_t wr_pd;
  logic  rd_pvld;
  logic  rd_prdy;
  data_t rd_pd;
  logic  ram_we;
  addr_t ram_wa;
  data_t ram_di;
  logic  ram_re;
  addr_t ram_ra;
  data_t ram_dout;
  cnt_t  count;

  modport slave (
    input  flush, wr_pvld, wr_pd, rd_prdy, ram_dout,
    output wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di, ram_re, ram_ra, count
  );

  modport master (
    output flush, wr_pvld, wr_pd, rd_prdy, ram_dout,
    input  wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_di, ram_re, ram_ra, count
  );

endinterface

// File: rtl/nv_ram_rws_128x18_fifo_ctrl.sv
// Sequencing controller that turns a registered-read-address RAM into a
// valid/ready FIFO. The RAM output is presented directly as the FIFO
// output; one entry is "on the output" (out_vld_q) while the rest wait in
// RAM. Full/empty come from the occupancy count alone, so the pointers
// carry no wrap bit.
module nv_ram_rws_128x18_fifo_ctrl import nv_ram_rws_128x18_fifo_ctrl_pkg::*; (
  input logic clk,
  input logic rst,
  nv_ram_rws_128x18_fifo_ctrl_if.slave bus_io
);

  addr_t wr_ptr_q, wr_ptr_d;
  addr_t rd_ptr_q, rd_ptr_d;
  cnt_t  count_q, count_d;
  logic  out_vld_q, out_vld_d;
  logic  rdy_q;

  logic  wr_prdy_w;
  logic  push;
  logic  pop;
  logic  issue;
  cnt_t  unread;

  // Handshake decode: push/pop qualification and read-issue decision.
  always_comb begin
    wr_prdy_w = rdy_q & ~bus_io.flush & (count_q < cnt_t'(DEPTH));
    push      = bus_io.wr_pvld & wr_prdy_w;
    pop       = out_vld_q & bus_io.rd_prdy;
    // Entries still sitting in RAM, i.e. not yet presented on rd_pd.
    unread    = count_q - cnt_t'(out_vld_q);
    // Load the next read address when the output slot is free or being
    // vacated this cycle; the RAM delivers it on the following cycle.
    issue     = ~bus_io.flush & (unread != '0) & (~out_vld_q | pop);
  end

  // Next-state computation for pointers, count and output-valid flag.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    out_vld_d = out_vld_q;
    if (bus_io.flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      out_vld_d = 1'b0;
    end else begin
      if (push)  wr_ptr_d = wr_ptr_q + addr_t'(1);
      if (issue) rd_ptr_d = rd_ptr_q + addr_t'(1);
      if (push & ~pop)      count_d = count_q + cnt_t'(1);
      else if (pop & ~push) count_d = count_q - cnt_t'(1);
      if (issue)    out_vld_d = 1'b1;
      else if (pop) out_vld_d = 1'b0;
    end
  end

  // State registers; rdy_q holds off pushes until the first edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_vld_q <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      out_vld_q <= out_vld_d;
      rdy_q     <= 1'b1;
    end
  end

  // Output drive: RAM ports follow the pointers even when idle (no X).
  always_comb begin
    bus_io.wr_prdy = wr_prdy_w;
    bus_io.rd_pvld = out_vld_q;
    bus_io.rd_pd   = bus_io.ram_dout;
    bus_io.ram_we  = push;
    bus_io.ram_wa  = wr_ptr_q;
    bus_io.ram_di  = bus_io.wr_pd;
    bus_io.ram_re  = issue;
    bus_io.ram_ra  = rd_ptr_q;
    bus_io.count   = count_q;
  end

`ifndef SYNTHESIS
  // A simultaneous write and read never target the same RAM slot.
  a_no_rw_collision: assert property (@(posedge clk) disable iff (rst)
    (bus_io.ram_we & bus_io.ram_re) |-> (bus_io.ram_wa != bus_io.ram_ra));

  // Occupancy never exceeds the RAM depth.
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count_q <= cnt_t'(DEPTH));

  // A stalled output entry keeps its payload.
  a_rd_pd_stable: assert property (@(posedge clk) disable iff (rst)
    (out_vld_q & ~bus_io.rd_prdy & ~bus_io.flush) |=> $stable(bus_io.rd_pd));
`endif

endmodule

// File: tb/tb_nv_ram_rws_128x18_fifo_ctrl.sv
// Directed bench for the FIFO controller with a behavioural model of the
// registered-read-address RAM beside it. Inputs are driven on the falling
// edge and outputs checked 1ns later, away from the rising edge.
module tb_nv_ram_rws_128x18_fifo_ctrl;
  import nv_ram_rws_128x18_fifo_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  nv_ram_rws_128x18_fifo_ctrl_if bus();

  nv_ram_rws_128x18_fifo_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.slave)
  );

  // RAM model: write on the edge, read address captured on ram_re,
  // data presented from the captured address.
  data_t mem [DEPTH];
  addr_t ra_q;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    ra_q = '0;
  end

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_wa] <= bus.ram_di;
    if (bus.ram_re) ra_q <= bus.ram_ra;
  end

  assign bus.ram_dout = mem[ra_q];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Push n words base..base+n-1, one per cycle, expecting each accepted.
  task automatic push_n(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.wr_pvld = 1'b1;
      bus.wr_pd   = data_t'(base + i);
      #1 check("push_rdy", bus.wr_prdy, 1);
      @(negedge clk);
    end
    bus.wr_pvld = 1'b0;
  endtask

  // Pop n words with rd_prdy held high, expecting base..base+n-1 back-to-back.
  task automatic drain_chk(input int base, input int n);
    bus.rd_prdy = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      check("drain_vld", bus.rd_pvld, 1);
      check("drain_pd", bus.rd_pd, base + i);
      @(negedge clk);
    end
    bus.rd_prdy = 1'b0;
  endtask

  initial begin
    int pushed;
    int popped;
    total = 0;
    bad   = 0;
    rst         = 1'b1;
    bus.flush   = 1'b0;
    bus.wr_pvld = 1'b0;
    bus.wr_pd   = '0;
    bus.rd_prdy = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_wr_prdy", bus.wr_prdy, 0);
    check("rst_rd_pvld", bus.rd_pvld, 0);
    check("rst_count", bus.count, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_ram_re", bus.ram_re, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1: single word, two-cycle latency.
    $display("test 1: single push latency");
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 18'h00001;
    #1;
    check("t1_wr_prdy", bus.wr_prdy, 1);
    check("t1_ram_we", bus.ram_we, 1);
    @(negedge clk);
    bus.wr_pvld = 1'b0;
    #1;
    check("t1_c1_rd_pvld", bus.rd_pvld, 0);
    check("t1_c1_ram_re", bus.ram_re, 1);
    check("t1_c1_count", bus.count, 1);
    @(negedge clk);
    #1;
    check("t1_c2_rd_pvld", bus.rd_pvld, 1);
    check("t1_c2_rd_pd", bus.rd_pd, 18'h00001);
    check("t1_c2_count", bus.count, 1);
    bus.rd_prdy = 1'b1;
    @(negedge clk);
    bus.rd_prdy = 1'b0;
    #1;
    check("t1_pop_count", bus.count, 0);
    check("t1_pop_rd_pvld", bus.rd_pvld, 0);

    // 2: fill to full, then drain in order.
    $display("test 2: fill 128 and drain");
    push_n(0, 128);
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 18'h3;
    #1;
    check("t2_full_count", bus.count, 128);
    check("t2_full_wr_prdy", bus.wr_prdy, 0);
    check("t2_full_ram_we", bus.ram_we, 0);
    bus.wr_pvld = 1'b0;
    drain_chk(0, 128);
    #1;
    check("t2_empty_count", bus.count, 0);
    check("t2_empty_rd_pvld", bus.rd_pvld, 0);
    check("t2_empty_ram_re", bus.ram_re, 0);

    // 3: full with simultaneous push and pop: pop only, push next cycle.
    $display("test 3: full, no ready-through");
    push_n(32'h100, 128);
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 18'h2AAAA;
    bus.rd_prdy = 1'b1;
    #1;
    check("t3_wr_prdy_full", bus.wr_prdy, 0);
    check("t3_ram_we_full", bus.ram_we, 0);
    check("t3_rd_pd_head", bus.rd_pd, 32'h100);
    @(negedge clk);
    bus.rd_prdy = 1'b0;
    #1;
    check("t3_count_127", bus.count, 127);
    check("t3_wr_prdy_127", bus.wr_prdy, 1);
    @(negedge clk);
    bus.wr_pvld = 1'b0;
    #1;
    check("t3_count_128", bus.count, 128);
    drain_chk(32'h101, 127);
    drain_chk(32'h2AAAA, 1);
    #1 check("t3_end_count", bus.count, 0);

    // 4: streaming 300 words, 1 per cycle, wrapping the pointers.
    $display("test 4: streaming 300 words");
    pushed = 0;
    popped = 0;
    bus.rd_prdy = 1'b1;
    for (int c = 0; c < 310; c++) begin
      bus.wr_pvld = (pushed < 300);
      bus.wr_pd   = data_t'(32'h3000 + pushed);
      #1;
      if (pushed < 300) begin
        check("t4_wr_prdy", bus.wr_prdy, 1);
        pushed++;
      end
      if (c == 2 || c == 150 || c == 299) check("t4_count_steady", bus.count, 2);
      if (c >= 2 && c <= 301) check("t4_rd_pvld", bus.rd_pvld, 1);
      if (bus.rd_pvld) begin
        check("t4_rd_pd", bus.rd_pd, 32'h3000 + popped);
        popped++;
      end
      @(negedge clk);
    end
    bus.wr_pvld = 1'b0;
    bus.rd_prdy = 1'b0;
    check("t4_popped", popped, 300);
    #1 check("t4_end_count", bus.count, 0);

    // 5: output stalled for 10 cycles holds its payload.
    $display("test 5: stall holds payload");
    push_n(32'h500, 5);
    for (int c = 0; c < 10; c++) begin
      #1;
      check("t5_rd_pvld", bus.rd_pvld, 1);
      check("t5_rd_pd", bus.rd_pd, 32'h500);
      check("t5_ram_re", bus.ram_re, 0);
      check("t5_count", bus.count, 5);
      @(negedge clk);
    end
    drain_chk(32'h500, 5);

    // 6: flush at 50 entries, then a new word is first out.
    $display("test 6: flush at 50 entries");
    push_n(32'h600, 50);
    bus.flush   = 1'b1;
    bus.rd_prdy = 1'b1;
    bus.wr_pvld = 1'b1;
    bus.wr_pd   = 18'h1234;
    #1;
    check("t6_flush_wr_prdy", bus.wr_prdy, 0);
    check("t6_flush_ram_re", bus.ram_re, 0);
    check("t6_flush_ram_we", bus.ram_we, 0);
    check("t6_flush_count", bus.count, 50);
    @(negedge clk);
    bus.flush   = 1'b0;
    bus.rd_prdy = 1'b0;
    bus.wr_pd   = 18'h3FFFF;
    #1;
    check("t6_after_count", bus.count, 0);
    check("t6_after_rd_pvld", bus.rd_pvld, 0);
    check("t6_push_rdy", bus.wr_prdy, 1);
    @(negedge clk);
    bus.wr_pvld = 1'b0;
    @(negedge clk);
    #1;
    check("t6_rd_pvld", bus.rd_pvld, 1);
    check("t6_rd_pd", bus.rd_pd, 18'h3FFFF);
    bus.rd_prdy = 1'b1;
    @(negedge clk);
    bus.rd_prdy = 1'b0;
    #1 check("t6_end_count", bus.count, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
